// File: rtl/wishbone_led_pwm.sv
// wishbone_led_pwm
// Wishbone slave driving NUM_LEDS LED pins. Each channel is either a static
// on/off level or a PWM output with its own duty register. A shared prescaler
// and PWM counter form the timebase. Duty writes land in a bus-visible register
// and reach the comparator only at the end of a PWM period, so a period is
// never cut short or stretched by a write. CTRL holds a global enable and an
// output inversion bit.
//
// Register map:
//   0x00 CTRL   bit0 EN, bit1 INV
//   0x01 MODE   bit i: 1 = channel i PWM, 0 = static
//   0x02 STATIC bit i: static level of channel i
//   0x03 BLINK  bit i: channel i blinks (only with WB_LED_BLINK_EN)
//   0x10+i      DUTY[i], low PWM_WIDTH bits
//   Any other address reads 0, ignores writes, and is still acknowledged.
//
// Optional feature macro: WB_LED_BLINK_EN. This macro adds the BLINK register
// and a phase flag that toggles every 2^BLINK_DIV PWM periods.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_wb_cyc    bus cycle
//   i_wb_stb    strobe
//   i_wb_we     write enable
//   i_wb_addr   register address  [ADDR_WIDTH]
//   i_wb_data   write data        [DATA_WIDTH]
//   o_wb_ack    one-cycle acknowledge
//   o_wb_stall  always 0
//   o_wb_data   read data, held between reads [DATA_WIDTH]
//   o_led       registered LED drive [NUM_LEDS]
module wishbone_led_pwm #(
    parameter int NUM_LEDS   = 6,
    parameter int PWM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int PRESCALE   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic [NUM_LEDS-1:0]   o_led
);
    localparam int                    PRE_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(PRESCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MODE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATIC = ADDR_WIDTH'(2);

    // Register file and timebase state
    logic                 en;
    logic                 inv;
    logic [NUM_LEDS-1:0]  mode;
    logic [NUM_LEDS-1:0]  static_lvl;
    logic [PWM_WIDTH-1:0] duty_bus [NUM_LEDS];
    logic [PWM_WIDTH-1:0] duty_act [NUM_LEDS];
    logic [PRE_W-1:0]     pre_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_LEDS-1:0]  led;

`ifdef WB_LED_BLINK_EN
    localparam int                    BLINK_DIV  = 6;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BLINK = ADDR_WIDTH'(3);
    logic [NUM_LEDS-1:0]  blink;
    logic [BLINK_DIV-1:0] blink_div;
    logic                 phase;
`endif

    logic                  accept;
    logic                  wr_en;
    logic                  tick;
    logic                  wrap;
    logic [NUM_LEDS-1:0]   duty_sel;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [NUM_LEDS-1:0]   raw;
    logic                  data_unused;

    // Only the low NUM_LEDS / PWM_WIDTH data bits are stored anywhere
    assign data_unused = ^i_wb_data;

    // A new request is taken only while no ack is pending. As a result,
    // back-to-back requests are answered on every other cycle.
    assign accept = i_wb_cyc & i_wb_stb & ~ack;
    assign wr_en  = accept & i_wb_we;
    assign tick   = (pre_cnt == PRE_LAST);
    assign wrap   = tick & (&pwm_cnt);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_sel[i] = (i_wb_addr == ADDR_WIDTH'(16 + i));
        end
    end

    always_comb begin
        rd_value = '0;
        if (i_wb_addr == ADDR_CTRL) begin
            rd_value[1:0] = {inv, en};
        end else if (i_wb_addr == ADDR_MODE) begin
            rd_value[NUM_LEDS-1:0] = mode;
        end else if (i_wb_addr == ADDR_STATIC) begin
            rd_value[NUM_LEDS-1:0] = static_lvl;
`ifdef WB_LED_BLINK_EN
        end else if (i_wb_addr == ADDR_BLINK) begin
            rd_value[NUM_LEDS-1:0] = blink;
`endif
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (duty_sel[i]) rd_value[PWM_WIDTH-1:0] = duty_bus[i];
        end
    end

    // Raw channel level before the enable and inversion are applied
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            raw[i] = mode[i] ? (pwm_cnt < duty_act[i]) : static_lvl[i];
        end
`ifdef WB_LED_BLINK_EN
        raw = raw & (~blink | {NUM_LEDS{phase}});
`endif
    end

    // NOTE: state is updated with non-blocking assignments. Every right-hand
    // side therefore sees pre-edge values. For example, a read returns the
    // value from before a same-edge write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            en         <= 1'b0;
            inv        <= 1'b0;
            mode       <= '0;
            static_lvl <= '0;
            // NOTE: the duty registers are a small register file, not a RAM.
            // They must read back 0 after reset, so each entry is cleared here.
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_bus[i] <= '0;
                duty_act[i] <= '0;
            end
            pre_cnt <= '0;
            pwm_cnt <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            led     <= '0;
`ifdef WB_LED_BLINK_EN
            blink     <= '0;
            blink_div <= '0;
            phase     <= 1'b0;
`endif
        end else begin
            // PWM timebase
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            // New duty values take effect only at the period boundary
            if (wrap) begin
                for (int i = 0; i < NUM_LEDS; i++) duty_act[i] <= duty_bus[i];
            end

            // Bus side
            ack <= accept;
            if (accept && !i_wb_we) rdata <= rd_value;
            if (wr_en) begin
                if (i_wb_addr == ADDR_CTRL) begin
                    en  <= i_wb_data[0];
                    inv <= i_wb_data[1];
                end
                if (i_wb_addr == ADDR_MODE)   mode       <= i_wb_data[NUM_LEDS-1:0];
                if (i_wb_addr == ADDR_STATIC) static_lvl <= i_wb_data[NUM_LEDS-1:0];
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (duty_sel[i]) duty_bus[i] <= i_wb_data[PWM_WIDTH-1:0];
                end
            end

`ifdef WB_LED_BLINK_EN
            if (wr_en && i_wb_addr == ADDR_BLINK) blink <= i_wb_data[NUM_LEDS-1:0];
            // A CTRL write restarts the blink pattern from the off phase
            if (wr_en && i_wb_addr == ADDR_CTRL) begin
                blink_div <= '0;
                phase     <= 1'b0;
            end else if (wrap) begin
                blink_div <= blink_div + 1'b1;
                if (&blink_div) phase <= ~phase;
            end
`endif

            led <= ({NUM_LEDS{en}} & raw) ^ {NUM_LEDS{inv}};
        end
    end

    assign o_wb_ack   = ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata;
    assign o_led      = led;

endmodule

// File: tb/tb_wishbone_led_pwm.sv
// tb_wishbone_led_pwm
// Self-checking bench for wishbone_led_pwm. A behavioural model tracks the
// register contents and the elapsed clock count. From these it derives the
// PWM counter arithmetically and predicts ack, read data and o_led for every
// clock edge. Directed scenarios cover the following: reset, static and
// inverted outputs, duty ratio, duty shadowing, back-to-back reads, unused
// addresses and reset during a transaction. Random bus traffic follows.
module tb_wishbone_led_pwm;
    localparam int NL     = 6;
    localparam int PW     = 8;
    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int P      = 4;
    localparam int STEPS  = 1 << PW;
    localparam int PERIOD = P * STEPS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          stall;
    logic [DW-1:0] rdata;
    logic [NL-1:0] led;

    always #5 clk = ~clk;

    wishbone_led_pwm #(
        .NUM_LEDS  (NL),
        .PWM_WIDTH (PW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PRESCALE  (P)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_addr (addr),
        .i_wb_data (wdata),
        .o_wb_ack  (ack),
        .o_wb_stall(stall),
        .o_wb_data (rdata),
        .o_led     (led)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int hi_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    bit          m_en;
    bit          m_inv;
    bit [NL-1:0] m_mode;
    bit [NL-1:0] m_static;
    bit [NL-1:0] m_blink;
    int          m_duty_bus [NL];
    int          m_duty_act [NL];
    int          m_n;        // clock edges since reset release
    int          m_periods;  // PWM periods since the last CTRL write
    bit          m_ack;
    int          m_rdata;
    bit [NL-1:0] m_led;

    function automatic int model_read(input int a);
        if (a == 0) return int'({m_inv, m_en});
        if (a == 1) return int'(m_mode);
        if (a == 2) return int'(m_static);
`ifdef WB_LED_BLINK_EN
        if (a == 3) return int'(m_blink);
`endif
        if (a >= 16 && a < 16 + NL) return m_duty_bus[a-16];
        return 0;
    endfunction

    task automatic model_write(input int a, input int d);
        if (a == 0) begin
            m_en      = d[0];
            m_inv     = d[1];
            m_periods = 0;
        end
        if (a == 1) m_mode = d[NL-1:0];
        if (a == 2) m_static = d[NL-1:0];
`ifdef WB_LED_BLINK_EN
        if (a == 3) m_blink = d[NL-1:0];
`endif
        if (a >= 16 && a < 16 + NL) m_duty_bus[a-16] = d % STEPS;
    endtask

    // LED value produced at an edge, computed from the state before that edge
    function automatic bit [NL-1:0] model_led();
        bit [NL-1:0] raw;
        int          cnt;
        cnt = (m_n / P) % STEPS;
        for (int i = 0; i < NL; i++) begin
            raw[i] = m_mode[i] ? (cnt < m_duty_act[i]) : m_static[i];
        end
`ifdef WB_LED_BLINK_EN
        if (((m_periods / 64) % 2) == 0) raw = raw & ~m_blink;
`endif
        if (!m_en) raw = '0;
        return raw ^ {NL{m_inv}};
    endfunction

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_mode = '0; m_static = '0; m_blink = '0;
        for (int i = 0; i < NL; i++) begin
            m_duty_bus[i] = 0;
            m_duty_act[i] = 0;
        end
        m_n = 0; m_periods = 0; m_ack = 0; m_rdata = 0; m_led = '0;
    endtask

    // One clock: advance the model across the rising edge, then compare on
    // the falling edge
    task automatic tick();
        bit accept;
        int a;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_led = model_led();
            m_n++;
            if (m_n % PERIOD == 0) begin
                for (int i = 0; i < NL; i++) m_duty_act[i] = m_duty_bus[i];
                m_periods++;
            end
            accept = cyc && stb && !m_ack;
            a      = int'(addr);
            if (accept && !we) m_rdata = model_read(a);
            if (accept && we) model_write(a, int'(wdata));
            m_ack = accept;
        end
        @(negedge clk);
        check("ack", 32'(ack), 32'(m_ack));
        check("led", 32'(led), 32'(m_led));
        if (m_ack) check("rdata", 32'(rdata), 32'(m_rdata));
        if (led[0]) hi_cnt++;
    endtask

    task automatic bus_write(input int a, input int d);
        cyc = 1; stb = 1; we = 1; addr = AW'(a); wdata = DW'(d);
        tick();
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    task automatic bus_read(input int a, output int d);
        cyc = 1; stb = 1; we = 0; addr = AW'(a);
        tick();
        d   = int'(rdata);
        cyc = 0; stb = 0;
        tick();
    endtask

    int addr_pool [12] = '{0, 1, 2, 3, 16, 17, 18, 19, 20, 21, 22, 127};

    initial begin
        int d;
        int a;
        rst_n = 0; cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_led", 32'(led), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_data", 32'(rdata), 0);
        check("stall", 32'(stall), 0);
        rst_n = 1;

        bus_read(0, d);  check("rd_ctrl_rst", d, 0);
        bus_read(1, d);  check("rd_mode_rst", d, 0);
        bus_read(16, d); check("rd_duty0_rst", d, 0);

        // Static outputs, then inverted
        bus_write(0, 1);
        bus_write(1, 0);
        bus_write(2, 'h2A);
        check("static_led", 32'(led), 'h2A);
        bus_write(0, 3);
        check("inv_led", 32'(led), 'h15);

        // PWM on channel 0 with duty 64: 256 high clocks per 1024
        bus_write(0, 1);
        bus_write(2, 0);
        bus_write(16, 64);
        bus_write(1, 1);
        repeat (2 * PERIOD) tick();
        hi_cnt = 0;
        repeat (PERIOD) tick();
        check("duty64_high", hi_cnt, 256);

        // Duty change mid-period is deferred to the next period
        do tick(); while (m_n % PERIOD != 0);
        hi_cnt = 0;
        repeat (120) tick();
        bus_write(16, 192);
        bus_read(16, d);
        check("duty_readback", d, 192);
        do tick(); while (m_n % PERIOD != 0);
        check("old_duty_period", hi_cnt, 256);
        hi_cnt = 0;
        repeat (PERIOD) tick();
        check("new_duty_period", hi_cnt, 768);

        // Back-to-back reads: ack alternates
        cyc = 1; stb = 1; we = 0; addr = AW'(1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("b2b_ack", 32'(ack), (i % 2 == 0) ? 1 : 0);
        end
        cyc = 0; stb = 0;
        tick();

        // Unused addresses
        bus_read('h7F, d);  check("rd_7f", d, 0);
        bus_write('h7F, 'hFFFF);
        bus_read(0, d);     check("ctrl_after_7f", d, 1);
        bus_read(1, d);     check("mode_after_7f", d, 1);
        bus_read(2, d);     check("static_after_7f", d, 0);
        bus_read(16 + NL, d); check("rd_past_duty", d, 0);
`ifndef WB_LED_BLINK_EN
        bus_write(3, 'h3F);
        bus_read(3, d);     check("rd_03_unused", d, 0);
`endif

        // Random traffic
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) a = int'($urandom_range(0, 255));
            else a = addr_pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 1) == 1) bus_write(a, int'($urandom_range(0, 65535)));
            else bus_read(a, d);
            if ($urandom_range(0, 3) == 0) begin
                cyc = 1; stb = 0; we = 1; addr = AW'(0); wdata = '0;
                tick();
                cyc = 0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        check("stall_end", 32'(stall), 0);

        // Reset during an accepted write
        bus_write(0, 3);
        bus_write(1, 'h3F);
        cyc = 1; stb = 1; we = 1; addr = AW'(2); wdata = DW'('h3F);
        tick();
        rst_n = 0;
        tick();
        check("rst_mid_ack", 32'(ack), 0);
        check("rst_mid_led", 32'(led), 0);
        cyc = 0; stb = 0; we = 0;
        rst_n = 1;
        tick();
        bus_read(0, d);  check("ctrl_after_rst", d, 0);
        bus_read(1, d);  check("mode_after_rst", d, 0);
        bus_read(2, d);  check("static_after_rst", d, 0);
        bus_read(16, d); check("duty0_after_rst", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
